// File: rtl/micro86_pkg.sv
// Shared encodings for the micro86 execute stage: ALU ops, FLAGS bit positions,
// carry ops, Jcc condition nibbles and the FLAGS reset value.
package micro86_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_ADC = 3'd1,
    OP_SUB = 3'd2,
    OP_SBB = 3'd3,
    OP_AND = 3'd4,
    OP_XOR = 3'd5,
    OP_OR  = 3'd6,
    OP_CMP = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    CARRY_NONE = 2'd0,
    CARRY_CLC  = 2'd1,
    CARRY_STC  = 2'd2,
    CARRY_CMC  = 2'd3
  } carry_op_e;

  typedef enum logic [3:0] {
    COND_B  = 4'h2,
    COND_AE = 4'h3,
    COND_E  = 4'h4,
    COND_NE = 4'h5,
    COND_BE = 4'h6,
    COND_A  = 4'h7,
    COND_S  = 4'h8,
    COND_NS = 4'h9,
    COND_P  = 4'hA,
    COND_NP = 4'hB
  } cond_e;

  localparam int FLAG_CF = 0;
  localparam int FLAG_PF = 2;
  localparam int FLAG_AF = 4;
  localparam int FLAG_ZF = 6;
  localparam int FLAG_SF = 7;

  localparam logic [7:0] FLAGS_RESET = 8'h02;

  // Only the architecturally writable FLAGS bits are held in state.
  typedef struct packed {
    logic sf;
    logic zf;
    logic af;
    logic pf;
    logic cf;
  } flag_bits_t;

  typedef struct packed {
    logic [2:0] dest;
    logic [7:0] data;
  } wb_entry_t;

  function automatic logic even_parity(input logic [7:0] v);
    return ~^v;
  endfunction

  function automatic logic is_arith(input logic [2:0] op);
    return (op <= OP_SBB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational next-flags from an ALU result and its operands; zero latency.
// No backpressure; PF honours PARITY_FLAG_EN (tied 0 when undefined).
module alu_flag_calc
  import micro86_pkg::*;
(
  input  logic [2:0]  command,
  input  logic [8:0]  result,
  input  logic [7:0]  data_0,
  input  logic [7:0]  data_1,
  output flag_bits_t  flags
);

  logic arith;
  logic unused_operand_bits;

  always_comb begin
    arith    = is_arith(command);
    flags.cf = arith & result[8];
    flags.zf = (result[7:0] == 8'h00);
    flags.sf = result[7];
    // AF is the carry into bit 4, recovered from the operand/result bit-4 difference.
    flags.af = arith & (result[4] ^ data_0[4] ^ data_1[4]);
`ifdef PARITY_FLAG_EN
    flags.pf = even_parity(result[7:0]);
`else
    flags.pf = 1'b0;
`endif
  end

  assign unused_operand_bits = ^{data_0[7:5], data_0[3:0], data_1[7:5], data_1[3:0]};

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback/FLAGS stage (PARITY_FLAG_EN enables PF); 1-cycle accept-to-writeback, cond_true combinational.
// Single-entry writeback buffer: in_ready = !wb_valid || wb_ready, entry held stable while stalled.
module alu_writeback
  import micro86_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_command,
  input  logic [8:0]  in_result,
  input  logic [7:0]  in_data_0,
  input  logic [7:0]  in_data_1,
  input  logic [2:0]  in_dest,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [2:0]  wb_dest,
  output logic [7:0]  wb_data,
  output logic [7:0]  flags,
  input  logic        flag_load,
  input  logic [7:0]  flag_load_data,
  input  logic [1:0]  carry_op,
  input  logic [3:0]  cond,
  output logic        cond_true
);

  flag_bits_t flags_q;
  flag_bits_t flags_d;
  flag_bits_t alu_flags;
  wb_entry_t  wb_q;
  logic       accept;
  logic       unused_load_bits;

  alu_flag_calc u_flag_calc (
    .command (in_command),
    .result  (in_result),
    .data_0  (in_data_0),
    .data_1  (in_data_1),
    .flags   (alu_flags)
  );

  assign in_ready = !wb_valid || wb_ready;
  assign accept   = in_valid && in_ready;
  assign wb_dest  = wb_q.dest;
  assign wb_data  = wb_q.data;

  always_comb begin
    flags_d = flags_q;
    if (flag_load) begin
      flags_d.cf = flag_load_data[FLAG_CF];
      flags_d.pf = flag_load_data[FLAG_PF];
      flags_d.af = flag_load_data[FLAG_AF];
      flags_d.zf = flag_load_data[FLAG_ZF];
      flags_d.sf = flag_load_data[FLAG_SF];
    end else if (accept) begin
      flags_d = alu_flags;
    end else begin
      case (carry_op)
        CARRY_CLC: flags_d.cf = 1'b0;
        CARRY_STC: flags_d.cf = 1'b1;
        CARRY_CMC: flags_d.cf = ~flags_q.cf;
        default:   flags_d.cf = flags_q.cf;
      endcase
    end
`ifndef PARITY_FLAG_EN
    flags_d.pf = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q  <= '0;
      wb_valid <= 1'b0;
      wb_q     <= '0;
    end else begin
      flags_q <= flags_d;
      if (accept && (in_command != OP_CMP)) begin
        wb_valid  <= 1'b1;
        wb_q.dest <= in_dest;
        wb_q.data <= in_result[7:0];
      end else if (wb_ready) begin
        wb_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    flags          = FLAGS_RESET;
    flags[FLAG_CF] = flags_q.cf;
    flags[FLAG_PF] = flags_q.pf;
    flags[FLAG_AF] = flags_q.af;
    flags[FLAG_ZF] = flags_q.zf;
    flags[FLAG_SF] = flags_q.sf;
  end

  // OF is not tracked, so the overflow/signed conditions evaluate false.
  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_B:  cond_true = flags_q.cf;
      COND_AE: cond_true = ~flags_q.cf;
      COND_E:  cond_true = flags_q.zf;
      COND_NE: cond_true = ~flags_q.zf;
      COND_BE: cond_true = flags_q.cf | flags_q.zf;
      COND_A:  cond_true = ~(flags_q.cf | flags_q.zf);
      COND_S:  cond_true = flags_q.sf;
      COND_NS: cond_true = ~flags_q.sf;
`ifdef PARITY_FLAG_EN
      COND_P:  cond_true = flags_q.pf;
      COND_NP: cond_true = ~flags_q.pf;
`else
      COND_P:  cond_true = 1'b0;
      COND_NP: cond_true = 1'b1;
`endif
      default: cond_true = 1'b0;
    endcase
  end

`ifdef PARITY_FLAG_EN
  assign unused_load_bits = ^{flag_load_data[5], flag_load_data[3], flag_load_data[1]};
`else
  assign unused_load_bits = ^{flag_load_data[5], flag_load_data[3], flag_load_data[2], flag_load_data[1]};
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: writebacks are queued at drive time and
// checked when the register file takes them; flags/cond checked per scenario.
`timescale 1ns/1ps
module tb_alu_writeback;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_command;
  logic [8:0] in_result;
  logic [7:0] in_data_0;
  logic [7:0] in_data_1;
  logic [2:0] in_dest;
  logic       wb_valid;
  logic       wb_ready;
  logic [2:0] wb_dest;
  logic [7:0] wb_data;
  logic [7:0] flags;
  logic       flag_load;
  logic [7:0] flag_load_data;
  logic [1:0] carry_op;
  logic [3:0] cond;
  logic       cond_true;

`ifdef PARITY_FLAG_EN
  localparam bit PF_ON = 1'b1;
`else
  localparam bit PF_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0] dest;
    logic [7:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  alu_writeback dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_command     (in_command),
    .in_result      (in_result),
    .in_data_0      (in_data_0),
    .in_data_1      (in_data_1),
    .in_dest        (in_dest),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_dest        (wb_dest),
    .wb_data        (wb_data),
    .flags          (flags),
    .flag_load      (flag_load),
    .flag_load_data (flag_load_data),
    .carry_op       (carry_op),
    .cond           (cond),
    .cond_true      (cond_true)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+2, so the negedge sees what the next edge will consume.
  always @(negedge clk) begin
    if (!reset && wb_valid && wb_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL wb_unexpected: got dest=%0d data=%h, required no writeback", wb_dest, wb_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (wb_dest !== mon_e.dest || wb_data !== mon_e.data) begin
          bad++;
          $display("FAIL wb_scoreboard: got dest=%0d data=%h, required dest=%0d data=%h",
                   wb_dest, wb_data, mon_e.dest, mon_e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    flag_load = 1'b0;
    carry_op  = 2'd0;
  endtask

  task automatic drive_alu(input logic [2:0] cmd, input logic [8:0] res,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [2:0] dest);
    exp_t e;
    in_valid   = 1'b1;
    in_command = cmd;
    in_result  = res;
    in_data_0  = d0;
    in_data_1  = d1;
    in_dest    = dest;
    #1;
    if (in_ready && cmd != 3'd7) begin
      e.dest = dest;
      e.data = res[7:0];
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    wb_ready = 1'b0;
    in_command = 3'd0; in_result = '0; in_data_0 = '0; in_data_1 = '0; in_dest = '0;
    flag_load_data = '0; cond = 4'd0;
    step(); step();
    total++; if (flags !== 8'h02) begin bad++; $display("FAIL reset_flags: got %h required 02", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL reset_wb_valid: got %b required 0", wb_valid); end
    total++; if (wb_data !== 8'h00) begin bad++; $display("FAIL reset_wb_data: got %h required 00", wb_data); end
    total++; if (wb_dest !== 3'd0) begin bad++; $display("FAIL reset_wb_dest: got %0d required 0", wb_dest); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    reset = 1'b0;
  endtask

  task automatic test_add_hold();
    logic [7:0] ef;
    wb_ready = 1'b0;
    drive_alu(3'd0, 9'h100, 8'h80, 8'h80, 3'd3);
    step();
    idle();
    ef = PF_ON ? 8'h47 : 8'h43;
    total++; if (flags !== ef) begin bad++; $display("FAIL add_flags: got %h required %h", flags, ef); end
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL add_wb_valid: got %b required 1", wb_valid); end
    cond = 4'h4;
    #1;
    total++; if (cond_true !== 1'b1) begin bad++; $display("FAIL add_cond_e: got %b required 1", cond_true); end
    // Stalled entry must stay put while a new result waits.
    drive_alu(3'd0, 9'h055, 8'h00, 8'h00, 3'd5);
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_in_ready[%0d]: got %b required 0", i, in_ready); end
      step();
      total++;
      if (wb_valid !== 1'b1 || wb_dest !== 3'd3 || wb_data !== 8'h00) begin
        bad++;
        $display("FAIL hold_entry[%0d]: got v=%b dest=%0d data=%h required v=1 dest=3 data=00", i, wb_valid, wb_dest, wb_data);
      end
    end
    wb_ready = 1'b1;
    drive_alu(3'd0, 9'h055, 8'h00, 8'h00, 3'd5);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
    step();
    idle();
    total++; if (wb_data !== 8'h55 || wb_dest !== 3'd5) begin bad++; $display("FAIL release_entry: got dest=%0d data=%h required dest=5 data=55", wb_dest, wb_data); end
    ef = PF_ON ? 8'h16 : 8'h12;
    total++; if (flags !== ef) begin bad++; $display("FAIL release_flags: got %h required %h", flags, ef); end
  endtask

  task automatic test_cmp();
    logic [7:0] ef;
    drive_alu(3'd7, 9'h1FF, 8'h00, 8'h00, 3'd6);
    step();
    idle();
    ef = PF_ON ? 8'h97 : 8'h93;
    total++; if (flags !== ef) begin bad++; $display("FAIL cmp_flags: got %h required %h", flags, ef); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL cmp_no_wb: got %b required 0", wb_valid); end
    cond = 4'h6;
    #1;
    total++; if (cond_true !== 1'b1) begin bad++; $display("FAIL cmp_cond_be: got %b required 1", cond_true); end
    cond = 4'h7;
    #1;
    total++; if (cond_true !== 1'b0) begin bad++; $display("FAIL cmp_cond_a: got %b required 0", cond_true); end
  endtask

  task automatic test_flag_priority();
    logic [7:0]  ef;
    logic [15:0] ctab;
    drive_alu(3'd0, 9'h0A0, 8'h00, 8'h00, 3'd1);
    flag_load      = 1'b1;
    flag_load_data = 8'hFF;
    carry_op       = 2'd2;
    step();
    idle();
    ef = PF_ON ? 8'hD7 : 8'hD3;
    total++; if (flags !== ef) begin bad++; $display("FAIL prio_flags: got %h required %h", flags, ef); end
    total++; if (wb_valid !== 1'b1 || wb_data !== 8'hA0 || wb_dest !== 3'd1) begin bad++; $display("FAIL prio_wb: got v=%b dest=%0d data=%h required v=1 dest=1 data=a0", wb_valid, wb_dest, wb_data); end
    // CF=ZF=SF=1 here; PF follows the build.
    ctab = 16'h0154 | (PF_ON ? 16'h0400 : 16'h0800);
    for (int c = 0; c < 16; c++) begin
      cond = 4'(c);
      #1;
      total++; if (cond_true !== ctab[c]) begin bad++; $display("FAIL cond_table[%0h]: got %b required %b", c, cond_true, ctab[c]); end
    end
  endtask

  task automatic test_xor_carry();
    logic [7:0] ef;
    drive_alu(3'd5, 9'h003, 8'h10, 8'h00, 3'd2);
    step();
    idle();
    ef = PF_ON ? 8'h06 : 8'h02;
    total++; if (flags !== ef) begin bad++; $display("FAIL xor_flags: got %h required %h", flags, ef); end
    cond = 4'hA;
    #1;
    total++; if (cond_true !== PF_ON) begin bad++; $display("FAIL xor_cond_p: got %b required %b", cond_true, PF_ON); end
    cond = 4'hB;
    #1;
    total++; if (cond_true !== !PF_ON) begin bad++; $display("FAIL xor_cond_np: got %b required %b", cond_true, !PF_ON); end
    carry_op = 2'd3;
    step();
    idle();
    ef = PF_ON ? 8'h07 : 8'h03;
    total++; if (flags !== ef) begin bad++; $display("FAIL cmc_flags: got %h required %h", flags, ef); end
    carry_op = 2'd1;
    step();
    idle();
    ef = PF_ON ? 8'h06 : 8'h02;
    total++; if (flags !== ef) begin bad++; $display("FAIL clc_flags: got %h required %h", flags, ef); end
    drive_alu(3'd0, 9'h001, 8'h00, 8'h00, 3'd4);
    carry_op = 2'd2;
    step();
    idle();
    total++; if (flags !== 8'h02) begin bad++; $display("FAIL stc_vs_alu_flags: got %h required 02", flags); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    wb_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      d = 8'($urandom_range(0, 255));
      drive_alu(3'd0, {1'b0, d}, 8'h00, 8'h00, 3'(i));
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b required 1", i, in_ready); end
      step();
      total++; if (wb_data !== d || wb_dest !== 3'(i)) begin bad++; $display("FAIL b2b_entry[%0d]: got dest=%0d data=%h required dest=%0d data=%h", i, wb_dest, wb_data, i, d); end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    wb_ready = 1'b0;
    step();
    drive_alu(3'd0, 9'h180, 8'h00, 8'h00, 3'd6);
    step();
    idle();
    total++; if (wb_valid !== 1'b1) begin bad++; $display("FAIL pre_reset_wb_valid: got %b required 1", wb_valid); end
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    total++; if (flags !== 8'h02) begin bad++; $display("FAIL mid_reset_flags: got %h required 02", flags); end
    total++; if (wb_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_wb_valid: got %b required 0", wb_valid); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_reset_in_ready: got %b required 1", in_ready); end
    step();
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add_hold();
    test_cmp();
    test_flag_priority();
    test_xor_carry();
    test_back_to_back();
    test_reset_mid();
    wb_ready = 1'b1;
    repeat (3) step();
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL drain: got %0d pending required 0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
